// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation select encodings and FSM state type for the multicycle ALU
package alu_pkg;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHR   = 2'b10;
    localparam logic [1:0] GRP_SHL   = 2'b11;

    localparam logic [1:0] ARITH_A   = 2'b00;
    localparam logic [1:0] ARITH_ADD = 2'b01;
    localparam logic [1:0] ARITH_SUB = 2'b10;
    localparam logic [1:0] ARITH_DEC = 2'b11;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - combinational SLICE_W-bit ALU slice, time-multiplexed by alu_multicycle
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  logic [3:0]         sel,
    input  logic               left_in,
    input  logic               right_in,
    output logic [SLICE_W-1:0] f,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W:0]   sum;

    always_comb begin
        b_eff = '0;
        case (sel[1:0])
            ARITH_A:   b_eff = '0;
            ARITH_ADD: b_eff = b;
            ARITH_SUB: b_eff = ~b;
            ARITH_DEC: b_eff = '1;
            default:   b_eff = '0;
        endcase
        sum = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
    end

    always_comb begin
        f     = '0;
        cout  = 1'b0;
        c_msb = 1'b0;
        case (sel[3:2])
            GRP_ARITH: begin
                f     = sum[SLICE_W-1:0];
                cout  = sum[SLICE_W];
                // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
                c_msb = sum[SLICE_W-1] ^ a[SLICE_W-1] ^ b_eff[SLICE_W-1];
            end
            GRP_LOGIC: begin
                case (sel[1:0])
                    LOGIC_AND: f = a & b;
                    LOGIC_OR:  f = a | b;
                    LOGIC_XOR: f = a ^ b;
                    LOGIC_NOT: f = ~a;
                    default:   f = '0;
                endcase
            end
            GRP_SHR: begin
                f            = a >> 1;
                f[SLICE_W-1] = left_in;
                cout         = a[0];
            end
            default: begin
                f    = a << 1;
                f[0] = right_in;
                cout = a[SLICE_W-1];
            end
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - bit-serial-by-slice ALU with valid/ready request and response handshakes
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH-1:0]   a_q, b_q, acc_q;
    logic [3:0]         sel_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   base;
    logic [WIDTH-1:0]   a_sr, a_sl, res_next;
    logic [SLICE_W-1:0] s_f;
    logic               s_cout, s_cmsb;
    logic               last, fin_cout, accept;

    assign base = IDX_W'(cnt_q * SLICE_W);
    // Neighbour bits for the shifts come from pre-shifted copies, so the end slices see 0 naturally
    assign a_sr = a_q >> 1;
    assign a_sl = a_q << 1;

    alu_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a        (a_q[base +: SLICE_W]),
        .b        (b_q[base +: SLICE_W]),
        .cin      (carry_q),
        .sel      (sel_q),
        .left_in  (a_sr[base + IDX_W'(SLICE_W - 1)]),
        .right_in (a_sl[base]),
        .f        (s_f),
        .cout     (s_cout),
        .c_msb    (s_cmsb)
    );

    always_comb begin
        res_next                   = acc_q;
        res_next[base +: SLICE_W]  = s_f;
    end

    assign last = (cnt_q == CNT_W'(NSLICE - 1));

    // Shift-right carry-out is A[0], produced by slice 0 and parked in carry_q
    always_comb begin
        fin_cout = s_cout;
        case (sel_q[3:2])
            GRP_LOGIC: fin_cout = 1'b0;
            GRP_SHR:   fin_cout = (cnt_q == '0) ? s_cout : carry_q;
            default:   fin_cout = s_cout;
        endcase
    end

    assign req_ready_o = (state == S_IDLE) || ((state == S_DONE) && rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sel_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_o <= 1'b0;
            f_o         <= '0;
            cout_o      <= 1'b0;
            zero_o      <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            case (state)
                S_BUSY: begin
                    acc_q <= res_next;
                    if ((sel_q[3:2] == GRP_ARITH) || ((sel_q[3:2] == GRP_SHR) && (cnt_q == '0)))
                        carry_q <= s_cout;
                    if (last) begin
                        f_o         <= res_next;
                        cout_o      <= fin_cout;
                        zero_o      <= (res_next == '0);
                        ovf_o       <= (sel_q[3:2] == GRP_ARITH) && (s_cmsb ^ s_cout);
                        rsp_valid_o <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A new request may land in IDLE or on the same edge as a DONE handshake
            if (accept) begin
                a_q     <= a_i;
                b_q     <= b_i;
                sel_q   <= sel_i;
                carry_q <= cin_i;
                cnt_q   <= '0;
                state   <= S_BUSY;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle at SLICE_W 8, 1, 4 and 32
module tb_alu_multicycle;

    typedef struct packed {
        logic [31:0] f;
        logic        cout;
        logic        zero;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid_v [4];
    logic        req_ready_v [4];
    logic        cin_v       [4];
    logic        rsp_valid_v [4];
    logic        rsp_ready_v [4];
    logic        cout_v      [4];
    logic        zero_v      [4];
    logic        ovf_v       [4];
    logic [31:0] a_v         [4];
    logic [31:0] b_v         [4];
    logic [31:0] f_v         [4];
    logic [3:0]  sel_v       [4];

    int   nslice [4] = '{4, 32, 8, 1};
    res_t sb[$];
    int   total = 0;
    int   bad   = 0;

    genvar g;
    for (g = 0; g < 4; g++) begin : g_dut
        localparam int SW = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        alu_multicycle #(.WIDTH(32), .SLICE_W(SW)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .req_valid_i (req_valid_v[g]),
            .req_ready_o (req_ready_v[g]),
            .a_i         (a_v[g]),
            .b_i         (b_v[g]),
            .cin_i       (cin_v[g]),
            .sel_i       (sel_v[g]),
            .rsp_valid_o (rsp_valid_v[g]),
            .rsp_ready_i (rsp_ready_v[g]),
            .f_o         (f_v[g]),
            .cout_o      (cout_v[g]),
            .zero_o      (zero_v[g]),
            .ovf_o       (ovf_v[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic [3:0] sel);
        logic [31:0] bb;
        logic [32:0] s;
        res_t        r;
        r  = '0;
        bb = '0;
        case (sel[3:2])
            2'd0: begin
                case (sel[1:0])
                    2'd0: bb = 32'h0;
                    2'd1: bb = b;
                    2'd2: bb = ~b;
                    default: bb = 32'hFFFF_FFFF;
                endcase
                s      = {1'b0, a} + {1'b0, bb} + 33'(cin);
                r.f    = s[31:0];
                r.cout = s[32];
                r.ovf  = (a[31] == bb[31]) && (r.f[31] != a[31]);
            end
            2'd1: begin
                case (sel[1:0])
                    2'd0: r.f = a & b;
                    2'd1: r.f = a | b;
                    2'd2: r.f = a ^ b;
                    default: r.f = ~a;
                endcase
            end
            2'd2: begin
                r.f    = {1'b0, a[31:1]};
                r.cout = a[0];
            end
            default: begin
                r.f    = {a[30:0], 1'b0};
                r.cout = a[31];
            end
        endcase
        r.zero = (r.f == 32'h0);
        return r;
    endfunction

    function automatic res_t observed(input int idx);
        return {f_v[idx], cout_v[idx], zero_v[idx], ovf_v[idx]};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic compare_rsp(input int idx, input string tag);
        res_t e;
        if (sb.size() == 0) begin
            check({tag, "_spurious"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check(tag, {29'd0, observed(idx)}, {29'd0, e});
        end
    endtask

    task automatic wait_rsp(input int idx, input string tag);
        int lat = 0;
        while (!rsp_valid_v[idx] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(nslice[idx]));
    endtask

    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [3:0] sel, input res_t exp,
                          input string tag);
        @(negedge clk);
        a_v[idx] = a; b_v[idx] = b; cin_v[idx] = cin; sel_v[idx] = sel;
        req_valid_v[idx] = 1'b1;
        rsp_ready_v[idx] = 1'b1;
        #1;
        check({tag, "_rdy"}, 64'(req_ready_v[idx]), 64'd1);
        sb.push_back(exp);
        @(posedge clk);
        #1;
        req_valid_v[idx] = 1'b0;
        wait_rsp(idx, tag);
        compare_rsp(idx, tag);
        @(posedge clk);
        #1;
        check({tag, "_ack"}, 64'(rsp_valid_v[idx]), 64'd0);
    endtask

    task automatic run_random(input int idx, input int nops);
        int accepted  = 0;
        int responded = 0;
        int cyc       = 0;
        sb.delete();
        while ((accepted < nops || sb.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            rsp_ready_v[idx] = ($urandom_range(0, 2) != 0);
            if (accepted < nops) begin
                req_valid_v[idx] = $urandom_range(0, 1) != 0;
                a_v[idx]   = rnd_operand();
                b_v[idx]   = rnd_operand();
                cin_v[idx] = $urandom_range(0, 1) != 0;
                sel_v[idx] = 4'($urandom_range(0, 15));
            end else begin
                req_valid_v[idx] = 1'b0;
            end
            #1;
            if (rsp_valid_v[idx] && rsp_ready_v[idx]) begin
                compare_rsp(idx, "rand_rsp");
                responded++;
            end
            if (req_valid_v[idx] && req_ready_v[idx]) begin
                sb.push_back(model(a_v[idx], b_v[idx], cin_v[idx], sel_v[idx]));
                accepted++;
            end
        end
        check("rand_accepted", 64'(accepted), 64'(nops));
        check("rand_responded", 64'(responded), 64'(nops));
        @(negedge clk);
        req_valid_v[idx] = 1'b0;
        rsp_ready_v[idx] = 1'b0;
    endtask

    initial begin
        res_t e1, e2, snap;
        int   stale;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid_v[i] = 1'b0; rsp_ready_v[i] = 1'b0; cin_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; sel_v[i] = '0;
        end
        #2;
        check("reset_out", {27'd0, observed(0), rsp_valid_v[0], req_ready_v[0]},
              {27'd0, 35'd0, 1'b0, 1'b1});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'b0001, {32'h0000_0000, 1'b1, 1'b1, 1'b0}, "add_wrap");
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'b0001, {32'h8000_0000, 1'b0, 1'b0, 1'b1}, "add_ovf");
        run_op(0, 32'h0000_0005, 32'h0000_0005, 1'b1, 4'b0010, {32'h0000_0000, 1'b1, 1'b1, 1'b0}, "sub_eq");
        run_op(0, 32'h8000_0001, 32'h0000_0000, 1'b0, 4'b1000, {32'h4000_0000, 1'b1, 1'b0, 1'b0}, "shr");
        run_op(0, 32'h8000_0001, 32'h0000_0000, 1'b0, 4'b1100, {32'h0000_0002, 1'b1, 1'b0, 1'b0}, "shl");
        run_op(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'b0110, {32'hFF00_FF00, 1'b0, 1'b0, 1'b0}, "xor");

        e1 = model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 4'b0010);
        e2 = model(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 4'b0001);
        @(negedge clk);
        a_v[0] = 32'h1234_5678; b_v[0] = 32'h0F0F_0F0F; cin_v[0] = 1'b1; sel_v[0] = 4'b0010;
        req_valid_v[0] = 1'b1;
        rsp_ready_v[0] = 1'b0;
        sb.push_back(e1);
        @(posedge clk);
        #1;
        req_valid_v[0] = 1'b0;
        wait_rsp(0, "bp_first");
        snap = observed(0);
        compare_rsp(0, "bp_first");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {27'd0, observed(0), rsp_valid_v[0], req_ready_v[0]},
                  {27'd0, snap, 1'b1, 1'b0});
        end
        @(negedge clk);
        a_v[0] = 32'hDEAD_BEEF; b_v[0] = 32'h0123_4567; cin_v[0] = 1'b0; sel_v[0] = 4'b0001;
        req_valid_v[0] = 1'b1;
        rsp_ready_v[0] = 1'b1;
        #1;
        check("bp_same_edge_rdy", 64'(req_ready_v[0]), 64'd1);
        sb.push_back(e2);
        @(posedge clk);
        #1;
        req_valid_v[0] = 1'b0;
        check("bp_busy", 64'({rsp_valid_v[0], req_ready_v[0]}), 64'd0);
        wait_rsp(0, "bp_second");
        compare_rsp(0, "bp_second");

        @(negedge clk);
        a_v[0] = 32'h1111_1111; b_v[0] = 32'h2222_2222; cin_v[0] = 1'b0; sel_v[0] = 4'b0001;
        req_valid_v[0] = 1'b1;
        rsp_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy_out", {27'd0, observed(0), rsp_valid_v[0], req_ready_v[0]},
              {27'd0, 35'd0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (rsp_valid_v[0]) stale++;
        end
        check("rst_no_stale", 64'(stale), 64'd0);
        run_op(0, 32'h0000_0003, 32'h7FFF_FFFF, 1'b0, 4'b0001,
               model(32'h0000_0003, 32'h7FFF_FFFF, 1'b0, 4'b0001), "post_rst");

        for (int i = 0; i < 4; i++) run_random(i, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SLICE_W, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE_W; NSLICE = WIDTH/SLICE_W.
REQ-003 clk_i  input  1  single clock, all state on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  request valid; req_ready_o  output  1  block can accept.
REQ-006 a_i, b_i  input  WIDTH  operands; cin_i  input  1  carry-in; sel_i  input  4  operation select.
REQ-007 rsp_valid_o  output  1  result valid; rsp_ready_i  input  1  consumer accepts.
REQ-008 f_o  output  WIDTH  result; cout_o  output  1  carry/shifted-out bit; zero_o  output  1  f_o==0; ovf_o  output  1  signed overflow.

Function
REQ-009 Request accepted on a rising edge with req_valid_i && req_ready_o; a_i, b_i, cin_i, sel_i captured then; later input changes ignored.
REQ-010 sel_i[3:2]: 00 arithmetic, 01 logic, 10 shift right by 1, 11 shift left by 1.
REQ-011 Arithmetic sel_i[1:0]: 00 A+cin; 01 A+B+cin; 10 A+~B+cin; 11 A+all-ones+cin; cout_o = carry out of bit WIDTH-1.
REQ-012 Logic sel_i[1:0]: 00 A&B; 01 A|B; 10 A^B; 11 ~A; cout_o = 0.
REQ-013 Shift right: f_o = {0, A[WIDTH-1:1]}, cout_o = A[0]; shift left: f_o = {A[WIDTH-2:0], 0}, cout_o = A[WIDTH-1]; B and cin ignored.
REQ-014 ovf_o = carry into MSB XOR carry out of MSB for arithmetic ops; 0 otherwise.
REQ-015 FSM states IDLE, BUSY, DONE; IDLE->BUSY on accept; BUSY->DONE after NSLICE cycles; DONE->IDLE on rsp_ready_i without new accept; DONE->BUSY on rsp_ready_i with simultaneous accept.
REQ-016 BUSY computes slice k (bits k*SLICE_W+SLICE_W-1 .. k*SLICE_W), k = 0..NSLICE-1, LSB slice first, one slice per cycle; inter-slice carry held in a register, seeded from cin.
REQ-017 Latency: accept at edge T -> rsp_valid_o high after edge T+NSLICE.
REQ-018 req_ready_o = (state==IDLE) || (state==DONE && rsp_ready_i); combinational on rsp_ready_i only.
REQ-019 In DONE, rsp_valid_o=1 and f_o, cout_o, zero_o, ovf_o held stable until handshake (backpressure of any length).
REQ-020 rsp_valid_o = 0 in IDLE and BUSY; f_o, flags hold last completed result outside DONE.
REQ-021 req_valid_i during BUSY is not accepted and has no effect.

Reset
REQ-022 rst_ni low SHALL asynchronously force state IDLE, rsp_valid_o=0, req_ready_o=1 (once rsp path idle), f_o=0, cout_o=0, zero_o=0, ovf_o=0, slice counter and carry register 0.
REQ-023 Reset during BUSY or DONE SHALL abort the operation; no response for it is ever produced.

Structure
REQ-024 Package alu_pkg SHALL hold sel encodings (op-group and sub-op constants) and the FSM state enum.
REQ-025 One sub-module alu_slice: combinational SLICE_W-bit slice (a, b, cin, sel, left/right neighbour bits in, f, cout, carry-into-MSB out), instantiated once and time-multiplexed.

Verification
REQ-026 WIDTH=32, SLICE_W=8: A=0xFFFFFFFF, B=0x00000001, cin=0, sel=0001 -> f_o=0x00000000, cout_o=1, zero_o=1, ovf_o=0, rsp_valid_o 4 cycles after accept.
REQ-027 A=0x7FFFFFFF, B=0x00000001, cin=0, sel=0001 -> f_o=0x80000000, cout_o=0, ovf_o=1; A=5, B=5, cin=1, sel=0010 -> f_o=0, cout_o=1, zero_o=1.
REQ-028 A=0x80000001, sel=1000 -> f_o=0x40000000, cout_o=1; sel=1100 -> f_o=0x00000002, cout_o=1; A=0xF0F0F0F0, B=0x0FF00FF0, sel=0110 -> f_o=0xFF00FF00, cout_o=0.
REQ-029 Hold rsp_ready_i=0 for 10 cycles in DONE -> outputs stable, req_ready_o=0; then rsp_ready_i=1 with req_valid_i=1 -> same-edge accept, next result valid 4 cycles later.
REQ-030 Assert rst_ni low for 1 cycle mid-BUSY -> all outputs 0, state IDLE, no stale response; next request completes correctly.
REQ-031 Random ops vs reference model across SLICE_W in {1, 4, 32}, random backpressure; every accepted request yields exactly one in-order response.
